// File: rtl/mc51_mem_ctrl_pkg.sv
// Purpose : shared FSM state encodings, request types and default wait-state constants
//           for the mc51 memory controller and the control unit that drives it.
// Contents: state_e, req_e, ROM_WAIT_DEF/RAM_WAIT_DEF, decode_req() strobe decoder.
package mc51_mem_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DATA   = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        REQ_NONE  = 2'd0,
        REQ_FETCH = 2'd1,
        REQ_RAMRD = 2'd2,
        REQ_RAMWR = 2'd3
    } req_e;

    localparam int unsigned ROM_WAIT_DEF = 1;
    localparam int unsigned RAM_WAIT_DEF = 0;

    // Strobes are active low. rd_n and we_n low together is illegal and
    // decodes to no request; the caller flags it separately.
    function automatic req_e decode_req(input logic psen_n, input logic rd_n, input logic we_n);
        req_e r;
        r = REQ_NONE;
        if (!we_n && rd_n)
            r = REQ_RAMWR;
        else if (we_n && !rd_n && !psen_n)
            r = REQ_FETCH;
        else if (we_n && !rd_n && psen_n)
            r = REQ_RAMRD;
        return r;
    endfunction

endpackage

// File: rtl/mc51_mem_ctrl.sv
// Purpose : single-access memory controller between the mc51 CU and synchronous ROM / internal RAM.
// Latency : read rdy in cycle W+3, write rdy in cycle 2 (cycle 0 = strobe sampled in IDLE).
// Ports   : CU side (i_psen_n/i_rd_n/i_we_n/i_addr/i_wdata -> o_rdata/o_data_rdy/o_busy/o_bus_err);
//           memory side (o_rom_*, i_rom_rdata, o_ram_*, i_ram_rdata). No backpressure: strobes
//           are ignored while busy except for a full release, which aborts the access.
module mc51_mem_ctrl
    import mc51_mem_ctrl_pkg::*;
#(
    parameter int unsigned ROM_WAIT = ROM_WAIT_DEF,
    parameter int unsigned RAM_WAIT = RAM_WAIT_DEF
) (
    input  logic        clk,
    input  logic        reset_n,
    // CU side
    input  logic        i_psen_n,
    input  logic        i_rd_n,
    input  logic        i_we_n,
    input  logic [15:0] i_addr,
    input  logic [7:0]  i_wdata,
    output logic [7:0]  o_rdata,
    output logic        o_data_rdy,
    output logic        o_busy,
    output logic        o_bus_err,
    // memory side
    output logic [15:0] o_rom_addr,
    output logic        o_rom_en,
    input  logic [7:0]  i_rom_rdata,
    output logic [7:0]  o_ram_addr,
    output logic        o_ram_en,
    output logic        o_ram_we,
    output logic [7:0]  o_ram_wdata,
    input  logic [7:0]  i_ram_rdata
);

    localparam logic [2:0] ROM_W3 = 3'(ROM_WAIT);
    localparam logic [2:0] RAM_W3 = 3'(RAM_WAIT);

    state_e      state_q, state_d;
    req_e        req_q;
    logic [15:0] addr_q;
    logic [7:0]  wdata_q;
    logic [2:0]  cnt_q, cnt_d;
    logic [7:0]  rdata_q;
    logic        rdy_q;
    logic        err_q;

    req_e        req_c;
    logic        accept_c;
    logic        abort_c;
    logic        bus_err_c;
    logic        capture_c;

    assign req_c     = decode_req(i_psen_n, i_rd_n, i_we_n);
    assign accept_c  = (state_q == ST_IDLE) && (req_c != REQ_NONE);
    assign bus_err_c = (state_q == ST_IDLE) && !i_we_n && !i_rd_n;
    // Full strobe release while an access is in flight cancels it.
    assign abort_c   = i_psen_n && i_rd_n && i_we_n;
    // Read data is taken on the edge that ends the last DATA cycle, unless aborted there.
    assign capture_c = (state_q == ST_DATA) && (cnt_q == 3'd0) && !abort_c;

    // State register and datapath latches
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 3'd0;
            req_q   <= REQ_NONE;
            addr_q  <= 16'h0000;
            wdata_q <= 8'h00;
            rdata_q <= 8'h00;
            rdy_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdy_q   <= (state_d == ST_RESP);
            err_q   <= bus_err_c;
            if (accept_c) begin
                req_q   <= req_c;
                addr_q  <= i_addr;
                wdata_q <= i_wdata;
            end
            if (capture_c)
                rdata_q <= (req_q == REQ_FETCH) ? i_rom_rdata : i_ram_rdata;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_c)
                    state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (abort_c) begin
                    state_d = ST_IDLE;
                end else if (req_q == REQ_RAMWR) begin
                    state_d = ST_RESP;
                end else begin
                    state_d = ST_DATA;
                    cnt_d   = (req_q == REQ_FETCH) ? ROM_W3 : RAM_W3;
                end
            end
            ST_DATA: begin
                if (abort_c)
                    state_d = ST_IDLE;
                else if (cnt_q == 3'd0)
                    state_d = ST_RESP;
                else
                    cnt_d = cnt_q - 3'd1;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode: enables follow state and latched request only, never the live strobes.
    always_comb begin
        o_rom_en = 1'b0;
        o_ram_en = 1'b0;
        o_ram_we = 1'b0;
        case (state_q)
            ST_ACCESS: begin
                o_rom_en = (req_q == REQ_FETCH);
                o_ram_en = (req_q == REQ_RAMRD) || (req_q == REQ_RAMWR);
                o_ram_we = (req_q == REQ_RAMWR);
            end
            ST_DATA: begin
                o_rom_en = (req_q == REQ_FETCH);
                o_ram_en = (req_q == REQ_RAMRD);
            end
            default: begin
                o_rom_en = 1'b0;
                o_ram_en = 1'b0;
                o_ram_we = 1'b0;
            end
        endcase
    end

    assign o_busy      = (state_q != ST_IDLE);
    assign o_data_rdy  = rdy_q;
    assign o_bus_err   = err_q;
    assign o_rdata     = rdata_q;
    assign o_rom_addr  = addr_q;
    assign o_ram_addr  = addr_q[7:0];
    assign o_ram_wdata = wdata_q;

endmodule

// File: tb/tb_mc51_mem_ctrl.sv
// Purpose : self-checking bench for mc51_mem_ctrl with behavioural sync ROM/RAM models.
// Latency : expected rdy cycle and read data queued per request, popped on o_data_rdy.
// Checks  : enables/busy/addresses per cycle, bus error, abort, reset mid-access, back-to-back.
module tb_mc51_mem_ctrl;

    localparam int TB_ROM_WAIT = 1;
    localparam int TB_RAM_WAIT = 0;
    localparam int K_FETCH = 0;
    localparam int K_RAMRD = 1;
    localparam int K_RAMWR = 2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        i_psen_n, i_rd_n, i_we_n;
    logic [15:0] i_addr;
    logic [7:0]  i_wdata;
    logic [7:0]  o_rdata;
    logic        o_data_rdy, o_busy, o_bus_err;
    logic [15:0] o_rom_addr;
    logic        o_rom_en;
    logic [7:0]  i_rom_rdata;
    logic [7:0]  o_ram_addr;
    logic        o_ram_en, o_ram_we;
    logic [7:0]  o_ram_wdata;
    logic [7:0]  i_ram_rdata;

    mc51_mem_ctrl #(.ROM_WAIT(TB_ROM_WAIT), .RAM_WAIT(TB_RAM_WAIT)) dut (
        .clk(clk), .reset_n(reset_n),
        .i_psen_n(i_psen_n), .i_rd_n(i_rd_n), .i_we_n(i_we_n),
        .i_addr(i_addr), .i_wdata(i_wdata),
        .o_rdata(o_rdata), .o_data_rdy(o_data_rdy), .o_busy(o_busy), .o_bus_err(o_bus_err),
        .o_rom_addr(o_rom_addr), .o_rom_en(o_rom_en), .i_rom_rdata(i_rom_rdata),
        .o_ram_addr(o_ram_addr), .o_ram_en(o_ram_en), .o_ram_we(o_ram_we),
        .o_ram_wdata(o_ram_wdata), .i_ram_rdata(i_ram_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- memory models ----------------
    function automatic logic [7:0] rom_val(input logic [15:0] a);
        if (a == 16'h0123) return 8'hA5;
        return a[7:0] ^ a[15:8] ^ 8'h96;
    endfunction

    logic [7:0] rom_q = 8'h00;
    logic [7:0] ram [256];
    logic [7:0] ram_q = 8'h00;
    assign i_rom_rdata = rom_q;
    assign i_ram_rdata = ram_q;

    always @(posedge clk) begin
        if (o_rom_en) rom_q <= rom_val(o_rom_addr);
        if (o_ram_en) begin
            if (o_ram_we) ram[o_ram_addr] <= o_ram_wdata;
            else          ram_q <= ram[o_ram_addr];
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [7:0]  rdata;
        logic [31:0] due;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] exp_ram [256];
    logic [7:0] exp_last = 8'h00;
    int         total = 0;
    int         bad = 0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n && o_data_rdy) begin
            if (sb.size() == 0) begin
                check_val("spurious_rdy", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_val("rdata", {24'd0, o_rdata}, {24'd0, e.rdata});
                check_val("rdy_cycle", cyc, e.due);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic set_strobes(input int kind);
        i_psen_n = (kind == K_FETCH) ? 1'b0 : 1'b1;
        i_rd_n   = (kind == K_RAMWR) ? 1'b1 : 1'b0;
        i_we_n   = (kind == K_RAMWR) ? 1'b0 : 1'b1;
    endtask

    task automatic release_strobes();
        i_psen_n = 1'b1;
        i_rd_n   = 1'b1;
        i_we_n   = 1'b1;
    endtask

    // Called at a negedge in IDLE; returns at the negedge of the cycle after RESP.
    // abort_at >= 1 releases all strobes in that cycle; chain keeps strobes low through RESP.
    task automatic run_req(input int kind, input logic [15:0] addr, input logic [7:0] wd,
                           input int abort_at, input bit chain);
        int   w, last, act_hi, c0;
        bit   aborted, in_act;
        exp_t e;
        w       = (kind == K_FETCH) ? TB_ROM_WAIT : TB_RAM_WAIT;
        last    = (kind == K_RAMWR) ? 2 : w + 3;
        act_hi  = (kind == K_RAMWR) ? 1 : w + 2;
        aborted = (abort_at >= 1);
        if (aborted && abort_at < act_hi) act_hi = abort_at;
        set_strobes(kind);
        i_addr  = addr;
        i_wdata = wd;
        c0      = cyc;
        if (!aborted) begin
            if (kind == K_RAMRD) exp_last = exp_ram[addr[7:0]];
            if (kind == K_FETCH) exp_last = rom_val(addr);
            if (kind == K_RAMWR) exp_ram[addr[7:0]] = wd;
            e.rdata = exp_last;
            e.due   = 32'(c0 + last);
            sb.push_back(e);
        end
        for (int n = 0; n <= last; n++) begin
            if (n == 1) begin
                i_addr  = ~addr;
                i_wdata = ~wd;
            end
            if (aborted && n == abort_at) release_strobes();
            if (n == last && !chain) release_strobes();
            in_act = (n >= 1) && (n <= act_hi);
            check_val("rom_en", o_rom_en, in_act && kind == K_FETCH);
            check_val("ram_en", o_ram_en, in_act && kind != K_FETCH);
            check_val("ram_we", o_ram_we, in_act && kind == K_RAMWR);
            check_val("busy", o_busy, aborted ? in_act : (n >= 1 && n <= last));
            if (in_act) begin
                if (kind == K_FETCH) check_val("rom_addr", o_rom_addr, addr);
                else                 check_val("ram_addr", o_ram_addr, addr[7:0]);
                if (kind == K_RAMWR) check_val("ram_wdata", o_ram_wdata, wd);
            end
            if (aborted && n == last) check_val("rdata_hold", o_rdata, exp_last);
            @(negedge clk);
        end
        check_val("sb_empty", sb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram[i]     = 8'(i) ^ 8'hC3;
            exp_ram[i] = 8'(i) ^ 8'hC3;
        end
        ram[8'h30]     = 8'h5A;
        exp_ram[8'h30] = 8'h5A;

        reset_n = 1'b0;
        release_strobes();
        i_addr  = 16'h0;
        i_wdata = 8'h0;
        #1;
        check_val("rst_rdata", o_rdata, 8'h00);
        check_val("rst_rdy", o_data_rdy, 1'b0);
        check_val("rst_busy", o_busy, 1'b0);
        check_val("rst_enables", {o_rom_en, o_ram_en, o_ram_we, o_bus_err}, 4'b0);
        check_val("rst_addrs", {o_rom_addr, o_ram_addr, o_ram_wdata}, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // directed accesses
        run_req(K_FETCH, 16'h0123, 8'h00, -1, 1'b0);
        run_req(K_RAMRD, 16'h0030, 8'h00, -1, 1'b0);
        run_req(K_RAMWR, 16'h007F, 8'h3C, -1, 1'b0);
        run_req(K_RAMRD, 16'h007F, 8'h00, -1, 1'b0);

        // illegal strobe combination
        i_psen_n = 1'b1; i_rd_n = 1'b0; i_we_n = 1'b0;
        @(negedge clk);
        check_val("bus_err_pulse", o_bus_err, 1'b1);
        check_val("bus_err_busy", o_busy, 1'b0);
        check_val("bus_err_en", {o_rom_en, o_ram_en, o_ram_we}, 3'b0);
        release_strobes();
        @(negedge clk);
        check_val("bus_err_end", o_bus_err, 1'b0);
        check_val("bus_err_idle", o_busy, 1'b0);
        @(negedge clk);

        // fetch released in its first DATA cycle
        run_req(K_FETCH, 16'h4567, 8'h00, 2, 1'b0);

        // back-to-back fetches, then a mixed random run
        run_req(K_FETCH, 16'h1000, 8'h00, -1, 1'b1);
        run_req(K_FETCH, 16'h2001, 8'h00, -1, 1'b1);
        run_req(K_RAMRD, 16'h0030, 8'h00, -1, 1'b0);
        for (int i = 0; i < 24; i++) begin
            int         k;
            logic [15:0] a;
            k = int'($urandom_range(0, 2));
            a = 16'($urandom);
            run_req(k, a, 8'($urandom), -1, (i != 23) && ($urandom_range(0, 1) == 1));
        end

        // reset pulse during DATA of a fetch
        set_strobes(K_FETCH);
        i_addr = 16'h0ABC;
        repeat (2) @(negedge clk);
        check_val("pre_rst_busy", o_busy, 1'b1);
        reset_n = 1'b0;
        #1;
        check_val("mid_rst_rdata", o_rdata, 8'h00);
        check_val("mid_rst_busy", o_busy, 1'b0);
        check_val("mid_rst_rdy", o_data_rdy, 1'b0);
        check_val("mid_rst_en", {o_rom_en, o_ram_en, o_ram_we, o_bus_err}, 4'b0);
        check_val("mid_rst_addrs", {o_rom_addr, o_ram_addr, o_ram_wdata}, 32'd0);
        exp_last = 8'h00;
        release_strobes();
        @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        check_val("post_rst_rdata", o_rdata, 8'h00);
        run_req(K_FETCH, 16'hBEEF, 8'h00, -1, 1'b0);

        repeat (3) @(negedge clk);
        check_val("final_sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mc51_mem_ctrl.md
MC51_MEM_CTRL -- requirements
Module: mc51_mem_ctrl

Interface
REQ-001 SHALL have parameter ROM_WAIT, default 1, meaning extra program-memory wait cycles (0..7).
REQ-002 SHALL have parameter RAM_WAIT, default 0, meaning extra internal-RAM read wait cycles (0..7).
REQ-003 SHALL have one clock and an asynchronous active-low reset, with ports as follows.
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have these CU-side ports.
- i_psen_n  in  1  program-fetch strobe (active low, paired with i_rd_n).
- i_rd_n  in  1  read strobe.
- i_we_n  in  1  RAM write strobe.
- i_addr  in  16  access address: {pch,pcl} for fetch; [7:0] for RAM.
- i_wdata  in  8  write data.
- o_rdata  out  8  read data; holds its last captured value.
- o_data_rdy  out  1  access-complete pulse.
- o_busy  out  1  high when the state is not IDLE.
- o_bus_err  out  1  illegal-strobe pulse.
REQ-005 SHALL have these memory-side ports.
- o_rom_addr  out  16.
- o_rom_en  out  1.
- i_rom_rdata  in  8  synchronous ROM; data valid from the cycle after en.
- o_ram_addr  out  8.
- o_ram_en  out  1.
- o_ram_we  out  1.
- o_ram_wdata  out  8.
- i_ram_rdata  in  8  synchronous RAM.

Function
REQ-006 SHALL decode the request in IDLE from the strobes sampled at each rising edge.
- FETCH: psen_n=0, rd_n=0, we_n=1.
- RAMRD: psen_n=1, rd_n=0, we_n=1.
- RAMWR: we_n=0, rd_n=1.
- Any other combination with a strobe low: no request.
REQ-007 SHALL, when we_n=0 and rd_n=0 together in IDLE, pulse o_bus_err for 1 cycle, remain in IDLE and issue no memory enable.
REQ-008 SHALL implement the FSM states IDLE, ACCESS, DATA, RESP with these transitions.
- IDLE->ACCESS on a valid request.
- ACCESS->DATA for reads.
- ACCESS->RESP for writes.
- DATA->RESP after the wait count expires.
- RESP->IDLE unconditionally.
REQ-009 SHALL latch i_addr, i_wdata and the request type on IDLE->ACCESS and drive the memory ports from these latches, so the memory ports are insensitive to CU changes mid-access.
REQ-010 SHALL assert the enable in ACCESS: o_rom_en for FETCH, o_ram_en for RAMRD, o_ram_en plus o_ram_we for RAMWR; o_ram_we SHALL be high for exactly 1 cycle per write.
REQ-011 SHALL keep the enable high throughout DATA, with DATA lasting W+1 cycles (W=ROM_WAIT for FETCH, RAM_WAIT for RAMRD) counted by a 3-bit down-counter loaded on ACCESS->DATA.
REQ-012 SHALL capture i_rom_rdata or i_ram_rdata into o_rdata on the edge ending the final DATA cycle, and change o_rdata at no other time.
REQ-013 SHALL make o_data_rdy a registered output, high only in RESP, for exactly 1 cycle.
REQ-014 SHALL have these latencies, counting the cycle in which the strobe is first sampled low as cycle 0: read o_data_rdy in cycle W+3; write o_data_rdy in cycle 2.
REQ-015 SHALL ignore the strobes during RESP, and SHALL accept a new request sampled in the IDLE cycle directly after RESP (back-to-back fetches allowed).
REQ-016 SHALL, if all strobes go high during ACCESS or DATA, abort to IDLE next edge: no o_data_rdy, o_rdata unchanged, any write already issued remains committed.
REQ-017 SHALL keep the enables low in IDLE and RESP, and SHALL keep o_ram_addr and o_rom_addr stable from ACCESS through the final DATA cycle.

Reset
REQ-018 SHALL, on reset_n low, immediately force state=IDLE, counter=0, o_rdata=8'h00, o_data_rdy=0, o_busy=0, o_bus_err=0, all enables=0, addresses=0 and o_ram_wdata=0.
REQ-019 SHALL, on reset mid-access, issue no rdy pulse after reset release, and the first request after release SHALL follow the REQ-014 latency.

Structure
REQ-020 SHALL define FSM state encodings and the default wait-state constants in global_param.v, shared with mc51_cu.
REQ-021 SHALL be a single module with no sub-modules; the counter and FSM are inline.

Verification
REQ-022 SHALL cover these directed scenarios.
- FETCH at 16'h0123 with ROM_WAIT=1 and ROM word 8'hA5 -> o_rom_en high in cycles 1-3, o_data_rdy in cycle 4, o_rdata=8'hA5.
- RAMRD at 8'h30 with RAM_WAIT=0 and RAM 8'h5A -> o_ram_we=0, o_data_rdy in cycle 3, o_rdata=8'h5A.
- RAMWR of 8'h3C to 8'h7F -> o_ram_we pulse in cycle 1 only, o_data_rdy in cycle 2; a following RAMRD of 8'h7F returns 8'h3C.
- we_n=0 and rd_n=0 together -> o_bus_err 1-cycle pulse, no enable, no rdy, o_busy=0.
- FETCH strobes released in the first DATA cycle -> no rdy, o_rdata keeps its previous value, IDLE next cycle.
- reset_n pulsed low during DATA of a FETCH -> all outputs at reset values at once, no rdy; the next FETCH completes with rdy in cycle ROM_WAIT+3.
